// File: rtl/rtc_time_set_pkg.sv
// Shared types, encodings and BCD helpers for the RTC time-setting controller.
package rtc_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SET_HR  = 2'd1,
    SET_MIN = 2'd2,
    SET_SEC = 2'd3
  } state_e;

  localparam logic [1:0] EF_NONE    = 2'd0;
  localparam logic [1:0] EF_HOURS   = 2'd1;
  localparam logic [1:0] EF_MINUTES = 2'd2;
  localparam logic [1:0] EF_SECONDS = 2'd3;

  localparam logic [3:0] HR_MAX_M      = 4'd2;
  localparam logic [3:0] HR_MAX_L_AT_2 = 4'd3;
  localparam logic [3:0] MS_MAX_M      = 4'd5;
  localparam logic [3:0] BCD_MAX       = 4'd9;

  // A two-digit field is legal when both digits are decimal and it does not exceed max_m:max_l.
  function automatic logic bcd_legal(input logic [3:0] m, input logic [3:0] l,
                                     input logic [3:0] max_m, input logic [3:0] max_l_at_max);
    return (l <= BCD_MAX) && ((m < max_m) || ((m == max_m) && (l <= max_l_at_max)));
  endfunction

  function automatic logic [7:0] bcd_inc(input logic [3:0] m, input logic [3:0] l,
                                         input logic [3:0] max_m, input logic [3:0] max_l_at_max);
    if ((m == max_m) && (l == max_l_at_max)) return 8'h00;
    if (l == BCD_MAX) return {m + 4'd1, 4'd0};
    return {m, l + 4'd1};
  endfunction

  function automatic logic [1:0] edit_field_of(input state_e s);
    case (s)
      SET_HR:  return EF_HOURS;
      SET_MIN: return EF_MINUTES;
      SET_SEC: return EF_SECONDS;
      default: return EF_NONE;
    endcase
  endfunction

endpackage

// File: rtl/rtc_time_set_if.sv
// Button, current-time and load-port signals of the RTC time-setting controller.
interface rtc_time_set_if;
  logic       tick_1hz;
  logic       btn_mode;
  logic       btn_inc;
  logic [3:0] cur_hr_m, cur_hr_l, cur_min_m, cur_min_l, cur_sec_m, cur_sec_l;
  logic [3:0] set_hr_m, set_hr_l, set_min_m, set_min_l, set_sec_m, set_sec_l;
  logic       load;
  logic       set_active;
  logic [1:0] edit_field;

  modport master (
    output tick_1hz, btn_mode, btn_inc,
    output cur_hr_m, cur_hr_l, cur_min_m, cur_min_l, cur_sec_m, cur_sec_l,
    input  set_hr_m, set_hr_l, set_min_m, set_min_l, set_sec_m, set_sec_l,
    input  load, set_active, edit_field
  );

  modport slave (
    input  tick_1hz, btn_mode, btn_inc,
    input  cur_hr_m, cur_hr_l, cur_min_m, cur_min_l, cur_sec_m, cur_sec_l,
    output set_hr_m, set_hr_l, set_min_m, set_min_l, set_sec_m, set_sec_l,
    output load, set_active, edit_field
  );
endinterface

// File: rtl/rtc_time_set_btn_debounce.sv
// Push-button conditioner: two-flop synchroniser, stability counter and one-clk press pulse.
// With AUTO_REPEAT_EN defined the accepted level is also exported for hold detection.
module btn_debounce #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
`ifdef AUTO_REPEAT_EN
  output logic level_o,
`endif
  output logic press_o
);

  logic        sync1_q, sync2_q;
  logic        level_q, level_d, level_dly_q;
  logic        press_q;
  logic [15:0] cnt_q, cnt_d;

  // Counts consecutive synced samples that disagree with the accepted level.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == DEBOUNCE_CYCLES - 16'd1) begin
      cnt_d   = '0;
      level_d = sync2_q;
    end else begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      cnt_q       <= '0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
      press_q     <= 1'b0;
    end else begin
      sync1_q     <= btn_i;
      sync2_q     <= sync1_q;
      cnt_q       <= cnt_d;
      level_q     <= level_d;
      level_dly_q <= level_q;
      press_q     <= level_q & ~level_dly_q;
    end
  end

  assign press_o = press_q;
`ifdef AUTO_REPEAT_EN
  assign level_o = level_q;
`endif

endmodule

// File: rtl/rtc_time_set.sv
// Button-driven HH:MM:SS editor producing BCD digits and a load strobe for the RTC core.
// Optional AUTO_REPEAT_EN: holding inc generates repeated increments.
module rtc_time_set
  import rtc_pkg::*;
#(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter logic [7:0]  TIMEOUT_S       = 8'd30
) (
  input  logic           clk,
  input  logic           reset_n,
  rtc_time_set_if.slave  bus
);

  logic rst_meta_q, rst_n_q;

  // Reset asserts asynchronously but is released on a clock edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rst_meta_q <= 1'b0;
      rst_n_q    <= 1'b0;
    end else begin
      rst_meta_q <= 1'b1;
      rst_n_q    <= rst_meta_q;
    end
  end

  logic [1:0] btn_raw, btn_press;
`ifdef AUTO_REPEAT_EN
  logic [1:0] btn_level;
`endif
  assign btn_raw = {bus.btn_inc, bus.btn_mode};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_btn
      btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
        .clk     (clk),
        .rst_n   (rst_n_q),
        .btn_i   (btn_raw[gi]),
`ifdef AUTO_REPEAT_EN
        .level_o (btn_level[gi]),
`endif
        .press_o (btn_press[gi])
      );
    end
  endgenerate

  logic mode_press, inc_evt;
  assign mode_press = btn_press[0];

`ifdef AUTO_REPEAT_EN
  localparam int REPEAT_SHIFT = 25;
  logic [REPEAT_SHIFT-1:0] rep_cnt_q;
  logic                    rep_armed_q, rep_pulse_q;

  // First repeat after 2^REPEAT_SHIFT clk of hold, then every quarter of that.
  always_ff @(posedge clk or negedge rst_n_q) begin
    if (!rst_n_q) begin
      rep_cnt_q   <= '0;
      rep_armed_q <= 1'b0;
      rep_pulse_q <= 1'b0;
    end else begin
      rep_pulse_q <= 1'b0;
      if (!btn_level[1]) begin
        rep_cnt_q   <= '0;
        rep_armed_q <= 1'b0;
      end else if ((!rep_armed_q && (&rep_cnt_q)) ||
                   (rep_armed_q && (&rep_cnt_q[REPEAT_SHIFT-3:0]))) begin
        rep_cnt_q   <= '0;
        rep_armed_q <= 1'b1;
        rep_pulse_q <= 1'b1;
      end else begin
        rep_cnt_q <= rep_cnt_q + 1'b1;
      end
    end
  end
  assign inc_evt = btn_press[1] | rep_pulse_q;
`else
  assign inc_evt = btn_press[1];
`endif

  state_e     state_q;
  logic [7:0] set_hr_q, set_min_q, set_sec_q;
  logic [7:0] timeout_q;
  logic       load_q;

  logic [7:0] cap_hr_d, cap_min_d, cap_sec_d;
  logic [7:0] inc_hr_d, inc_min_d, inc_sec_d;

  assign cap_hr_d  = bcd_legal(bus.cur_hr_m, bus.cur_hr_l, HR_MAX_M, HR_MAX_L_AT_2)
                     ? {bus.cur_hr_m, bus.cur_hr_l} : 8'h00;
  assign cap_min_d = bcd_legal(bus.cur_min_m, bus.cur_min_l, MS_MAX_M, BCD_MAX)
                     ? {bus.cur_min_m, bus.cur_min_l} : 8'h00;
  assign cap_sec_d = bcd_legal(bus.cur_sec_m, bus.cur_sec_l, MS_MAX_M, BCD_MAX)
                     ? {bus.cur_sec_m, bus.cur_sec_l} : 8'h00;
  assign inc_hr_d  = bcd_inc(set_hr_q[7:4],  set_hr_q[3:0],  HR_MAX_M, HR_MAX_L_AT_2);
  assign inc_min_d = bcd_inc(set_min_q[7:4], set_min_q[3:0], MS_MAX_M, BCD_MAX);
  assign inc_sec_d = bcd_inc(set_sec_q[7:4], set_sec_q[3:0], MS_MAX_M, BCD_MAX);

  // Mode beats inc in the same cycle; any accepted press restarts the inactivity timeout.
  always_ff @(posedge clk or negedge rst_n_q) begin
    if (!rst_n_q) begin
      state_q   <= RUN;
      set_hr_q  <= '0;
      set_min_q <= '0;
      set_sec_q <= '0;
      timeout_q <= '0;
      load_q    <= 1'b0;
    end else begin
      load_q <= 1'b0;
      if (mode_press) begin
        timeout_q <= '0;
        case (state_q)
          RUN: begin
            set_hr_q  <= cap_hr_d;
            set_min_q <= cap_min_d;
            set_sec_q <= cap_sec_d;
            state_q   <= SET_HR;
          end
          SET_HR:  state_q <= SET_MIN;
          SET_MIN: state_q <= SET_SEC;
          SET_SEC: begin
            state_q <= RUN;
            load_q  <= 1'b1;
          end
          default: state_q <= RUN;
        endcase
      end else if (inc_evt) begin
        timeout_q <= '0;
        case (state_q)
          SET_HR:  set_hr_q  <= inc_hr_d;
          SET_MIN: set_min_q <= inc_min_d;
          SET_SEC: set_sec_q <= inc_sec_d;
          default: ;
        endcase
      end else if (bus.tick_1hz && (state_q != RUN)) begin
        if (timeout_q == TIMEOUT_S - 8'd1) begin
          state_q   <= RUN;
          timeout_q <= '0;
        end else begin
          timeout_q <= timeout_q + 8'd1;
        end
      end
    end
  end

  assign bus.set_hr_m   = set_hr_q[7:4];
  assign bus.set_hr_l   = set_hr_q[3:0];
  assign bus.set_min_m  = set_min_q[7:4];
  assign bus.set_min_l  = set_min_q[3:0];
  assign bus.set_sec_m  = set_sec_q[7:4];
  assign bus.set_sec_l  = set_sec_q[3:0];
  assign bus.load       = load_q;
  assign bus.set_active = (state_q != RUN);
  assign bus.edit_field = edit_field_of(state_q);

endmodule
